// File: rtl/barcode_rdr.sv
// Single-wire barcode receiver: learns the cell period from the start bit,
// decodes 8 data bits MSB-first and holds the station ID with a sticky valid flag.
module barcode_rdr #(
   parameter int CNT_W = 22,
   parameter int MIN_T = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       BC,
   input  logic       clr_ID_vld,
   output logic [7:0] ID,
   output logic       ID_vld,
   output logic       BC_err
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MEAS      = 3'd1,
      WAIT_FALL = 3'd2,
      SAMPLE    = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] t_reg, t_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       id_reg, id_next;
   logic             vld_reg, vld_next;
   logic             err_reg, err_next;

   // [0],[1] form the metastability guard; [2] is the previous value for edges
   logic [2:0] sync_reg;
   logic       sync, prev, fall, rise;

   logic [CNT_W+1:0] t_x4;
   logic [CNT_W-1:0] limit;

   assign sync = sync_reg[1];
   assign prev = sync_reg[2];
   assign fall = prev & ~sync;
   assign rise = ~prev & sync;

   // Gap timeout of 4T, clamped to the counter range
   assign t_x4  = {t_reg, 2'b00};
   assign limit = (t_x4[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : t_x4[CNT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg    <= 3'b111;
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         t_reg       <= '0;
         bit_cnt_reg <= 3'd0;
         shift_reg   <= 8'h00;
         id_reg      <= 8'h00;
         vld_reg     <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         sync_reg    <= {sync_reg[1:0], BC};
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         t_reg       <= t_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         id_reg      <= id_next;
         vld_reg     <= vld_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      t_next       = t_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      id_next      = id_reg;
      vld_next     = vld_reg;
      err_next     = 1'b0;

      // Clear first so that a DONE set in the same cycle overrides it
      if (clr_ID_vld)
         vld_next = 1'b0;

      case (state_reg)
         IDLE: begin
            cnt_next     = '0;
            bit_cnt_next = 3'd0;
            if (fall)
               state_next = MEAS;
         end
         MEAS: begin
            if (rise) begin
               if (cnt_reg < CNT_W'(MIN_T)) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end else begin
                  t_next     = cnt_reg;
                  cnt_next   = '0;
                  state_next = WAIT_FALL;
               end
            end else if (cnt_reg == {CNT_W{1'b1}}) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_FALL: begin
            if (fall) begin
               cnt_next   = '0;
               state_next = SAMPLE;
            end else if (rise) begin
               cnt_next = '0;
            end else if (cnt_reg >= limit) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         SAMPLE: begin
            if (fall) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (cnt_reg == t_reg) begin
               shift_next   = {shift_reg[6:0], sync};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               cnt_next     = '0;
               state_next   = (bit_cnt_reg == 3'd7) ? DONE : WAIT_FALL;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            if (shift_reg[7:6] == 2'b00) begin
               id_next  = shift_reg;
               vld_next = 1'b1;
            end else begin
               err_next = 1'b1;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign ID     = id_reg;
   assign ID_vld = vld_reg;
   assign BC_err = err_reg;

endmodule

// File: doc/barcode_rdr.md
# barcode_rdr

Receiver for the single-wire barcode line (BC) driven by the station barcode transmitter, i.e. the far end of `barcode_mimic`. It synchronizes BC, measures the start-bit low time to learn the bit period, decodes 8 data bits MSB-first, and presents the station ID with a sticky valid flag. The Follower command logic reads it to detect arrival at a station.

## Interface
- `CNT_W`, default 22: width of the period and bit-timing counters. Must cover the longest low time, 3/4 of the cell.
- `MIN_T`, default 4: minimum accepted start-bit low count. Shorter start bits are treated as glitches.

Ports:
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `BC`  in  1  raw barcode line; idles high; asynchronous to `clk`
- `clr_ID_vld`  in  1  single-cycle pulse; clears `ID_vld`
- `ID`  out  8  last accepted station ID
- `ID_vld`  out  1  sticky; set when a valid ID is captured
- `BC_err`  out  1  one-cycle pulse when a frame is aborted or rejected

## Operation
Line protocol, with cell length P set by the transmitter:
- Every cell begins with a falling edge.
- Start cell: low for P/2.
- Data '1': low for P/4.
- Data '0': low for 3P/4.
- One start cell is followed by 8 data cells, MSB first.

Input conditioning:
- BC passes through 2 flops (metastability guard), then a third flop for edge detection.
- `fall` = prev & ~sync; `rise` = ~prev & sync.

States and transitions:
- IDLE:
  - cnt = 0, bit_cnt = 0.
  - On `fall` → MEAS.
- MEAS: count cycles while sync is low.
  - On `rise`: if cnt < MIN_T, abort. Otherwise T := cnt and go to WAIT_FALL.
  - If cnt reaches all-ones, abort.
- WAIT_FALL: cnt counts cycles since the last rise.
  - On `fall`: cnt := 0 and go to SAMPLE.
  - If cnt reaches 4·T (computed as T<<2, saturating at CNT_W), abort.
- SAMPLE: cnt counts from the falling edge.
  - When cnt == T: shift sync into shift[0], with the shift register moving left, and increment bit_cnt.
  - If bit_cnt was 7, go to DONE; otherwise go to WAIT_FALL.
  - A `fall` before cnt == T is impossible in a legal frame and aborts.
- DONE, lasting 1 cycle:
  - If shift[7:6] == 2'b00: ID := shift and set ID_vld.
  - Otherwise pulse BC_err, leave ID unchanged, and leave ID_vld unchanged.
  - Then go to IDLE.
- Abort: pulse BC_err for one cycle and go to IDLE. ID and ID_vld are not touched.

Flag rules:
- A new valid frame overwrites ID while ID_vld is already set.
- If `clr_ID_vld` and the DONE set occur in the same cycle, the set wins.

## Timing
Reset values:
- ID = 8'h00, ID_vld = 0, BC_err = 0.
- State = IDLE, T = 0, all counters = 0.
- Synchronizer flops reset to 1 (line idle), so no false `fall` is seen after reset.

Latency:
- Edge detection lags BC by 3 clk.
- The lag is identical for both edges, so the measured T is exact to within ±1 clk.
- Sample point: T clk after the detected falling edge of each data cell.
- ID and ID_vld update 1 clk after the sample of bit 0 (the LSB, sampled last).

Bit decision margins:
- A '1' has risen P/4 before the sample point.
- A '0' stays low until P/4 after the sample point.

Boundary conditions:
- Reset asserted mid-frame returns to IDLE immediately; the partial frame is discarded.
- BC held low forever: MEAS saturates, then aborts. `BC_err` pulses once and there is no re-trigger until the next `fall`.
- BC stuck high mid-frame: WAIT_FALL times out at 4·T and aborts.
- Back-to-back frames: the next frame's start `fall` arrives in IDLE and is accepted, because DONE lasts only 1 clk and the first idle gap is at least P/4.

## Test plan
1. **Valid frame.** After reset, drive P = 22'h1000 with station_ID 8'h01.
   - ID = 8'h01 and ID_vld = 1 within 20 clk of the final cell's sample point.
   - BC_err stays 0.
2. **Clear, then second frame.**
   - Pulse clr_ID_vld → ID_vld = 0 the next cycle.
   - Send 8'h2A with P = 22'h0400 → ID = 8'h2A and ID_vld = 1, showing T re-learned per frame.
3. **Invalid ID.** Send 8'hC5 (top bits ≠ 00).
   - One BC_err pulse.
   - ID keeps its previous value and ID_vld keeps its previous state.
4. **Start glitch.** Drive a BC low pulse of 2 clk.
   - BC_err pulses after the rise.
   - State returns to IDLE and a following legal frame of 8'h15 decodes correctly.
5. **Truncated frame.** Hold BC high after 3 data cells.
   - BC_err pulses 4·T + 3 clk after the last rise.
   - ID and ID_vld are unchanged.
6. **Reset mid-frame and set/clear collision.**
   - Assert rst during bit 4 → all outputs return to reset values and the frame is discarded.
   - Assert clr_ID_vld in the DONE cycle of a valid frame → ID_vld = 1.
